// File: rtl/mdu_hazard_ctrl.sv
// mdu_hazard_ctrl: multiply/divide issue, latency tracking, RAW/WAW/structural stall and write-port arbitration.
// Optional MDU_STATS_EN adds a saturating stall-cycle counter on Stall_Cnt_o.
module mdu_hazard_ctrl #(
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 6
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        IDEX_MDUValid_i,
   input  logic        IDEX_MDUOp_i,
   input  logic [4:0]  IDEX_RD_i,
   input  logic        IFID_MDUValid_i,
   input  logic [4:0]  IFID_RS_i,
   input  logic [4:0]  IFID_RT_i,
   input  logic [4:0]  IFID_RD_i,
   input  logic        IFID_RegWrite_i,
   input  logic        MEMWB_RegWrite_i,
   output logic        MDU_Start_o,
   output logic        MDU_Op_o,
   output logic        Stall_o,
   output logic        MDU_WE_o,
   output logic [4:0]  MDU_RD_o,
   output logic        WBSel_o,
   output logic        MDU_Busy_o,
   output logic [31:0] Stall_Cnt_o
);
   typedef enum logic [1:0] {IDLE, BUSY, WAIT_WB} state_t;
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
   state_t           state, state_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [4:0]       pend_rd, pend;
   logic             busy, wr;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         count    <= '0;
         pend_rd  <= '0;
         MDU_Op_o <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         if (MDU_Start_o) begin
            pend_rd  <= IDEX_RD_i;
            MDU_Op_o <= IDEX_MDUOp_i;
         end
      end
   end
   // The pipeline always owns the write port; the MDU retries each cycle from WAIT_WB.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      wr        = 1'b0;
      case (state)
         IDLE: if (IDEX_MDUValid_i) begin
            state_nxt = BUSY;
            count_nxt = IDEX_MDUOp_i ? DIV_CNT : MUL_CNT;
         end
         BUSY: if (count != '0) count_nxt = count - CNT_W'(1);
         else if (!MEMWB_RegWrite_i) begin
            wr        = 1'b1;
            state_nxt = IDLE;
         end else state_nxt = WAIT_WB;
         WAIT_WB: if (!MEMWB_RegWrite_i) begin
            wr        = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
   assign busy        = state != IDLE;
   assign MDU_Busy_o  = busy;
   assign MDU_Start_o = !busy && IDEX_MDUValid_i;
   assign MDU_WE_o    = wr && pend_rd != 5'd0;
   assign WBSel_o     = MDU_WE_o;
   assign MDU_RD_o    = busy ? pend_rd : 5'd0;
   assign pend        = busy ? pend_rd : (IDEX_MDUValid_i ? IDEX_RD_i : 5'd0);
   assign Stall_o     = (IFID_MDUValid_i && (busy || IDEX_MDUValid_i)) ||
                        (pend != 5'd0 && (IFID_RS_i == pend || IFID_RT_i == pend ||
                                          (IFID_RegWrite_i && IFID_RD_i == pend)));
`ifdef MDU_STATS_EN
   logic [31:0] stall_cnt;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) stall_cnt <= '0;
      else if (Stall_o && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
   end
   assign Stall_Cnt_o = stall_cnt;
`else
   assign Stall_Cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_mdu_hazard_ctrl.sv
// tb_mdu_hazard_ctrl: directed checks of mdu_hazard_ctrl with default latencies (MUL 3, DIV 32).
module tb_mdu_hazard_ctrl;
   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        IDEX_MDUValid_i, IDEX_MDUOp_i, IFID_MDUValid_i, IFID_RegWrite_i, MEMWB_RegWrite_i;
   logic [4:0]  IDEX_RD_i, IFID_RS_i, IFID_RT_i, IFID_RD_i;
   logic        MDU_Start_o, MDU_Op_o, Stall_o, MDU_WE_o, WBSel_o, MDU_Busy_o;
   logic [4:0]  MDU_RD_o;
   logic [31:0] Stall_Cnt_o;
   int total = 0, bad = 0;

   mdu_hazard_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .IDEX_MDUValid_i(IDEX_MDUValid_i), .IDEX_MDUOp_i(IDEX_MDUOp_i), .IDEX_RD_i(IDEX_RD_i),
      .IFID_MDUValid_i(IFID_MDUValid_i), .IFID_RS_i(IFID_RS_i), .IFID_RT_i(IFID_RT_i),
      .IFID_RD_i(IFID_RD_i), .IFID_RegWrite_i(IFID_RegWrite_i), .MEMWB_RegWrite_i(MEMWB_RegWrite_i),
      .MDU_Start_o(MDU_Start_o), .MDU_Op_o(MDU_Op_o), .Stall_o(Stall_o), .MDU_WE_o(MDU_WE_o),
      .MDU_RD_o(MDU_RD_o), .WBSel_o(WBSel_o), .MDU_Busy_o(MDU_Busy_o), .Stall_Cnt_o(Stall_Cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr();
      IDEX_MDUValid_i = 0; IDEX_MDUOp_i = 0; IDEX_RD_i = 0;
      IFID_MDUValid_i = 0; IFID_RS_i = 0; IFID_RT_i = 0; IFID_RD_i = 0;
      IFID_RegWrite_i = 0; MEMWB_RegWrite_i = 0;
   endtask

   initial begin
      clr();
      #12;
      chk("rst_busy", MDU_Busy_o, 0);
      chk("rst_rd", MDU_RD_o, 0);
      chk("rst_op", MDU_Op_o, 0);
      chk("rst_cnt", Stall_Cnt_o, 0);
      rst_i = 0;
      cyc();

      // 1: reset abandons an in-flight divide
      IDEX_MDUValid_i = 1; IDEX_MDUOp_i = 1; IDEX_RD_i = 8; IFID_RS_i = 8;
      #1 chk("t1_start", MDU_Start_o, 1);
      cyc();
      IDEX_MDUValid_i = 0;
      for (int i = 1; i < 10; i++) begin
         #1 chk("t1_we", MDU_WE_o, 0);
         chk("t1_busy", MDU_Busy_o, 1);
         chk("t1_opl", MDU_Op_o, 1);
         cyc();
      end
      rst_i = 1;
      #1 chk("t1_rbusy", MDU_Busy_o, 0);
      chk("t1_rstall", Stall_o, 0);
      chk("t1_rwe", MDU_WE_o, 0);
      cyc();
      rst_i = 0;
      clr();
      cyc();

      // 2+3: multiply timing with a RAW-dependent decode
      IDEX_MDUValid_i = 1; IDEX_RD_i = 5; IFID_RS_i = 5;
      #1 chk("t2_start0", MDU_Start_o, 1);
      chk("t3_stall0", Stall_o, 1);
      chk("t2_busy0", MDU_Busy_o, 0);
      cyc();
      IDEX_MDUValid_i = 0; IDEX_RD_i = 0;
      #1 chk("t2_start1", MDU_Start_o, 0);
      chk("t2_busy1", MDU_Busy_o, 1);
      chk("t2_rd1", MDU_RD_o, 5);
      chk("t2_we1", MDU_WE_o, 0);
      chk("t3_stall1", Stall_o, 1);
      cyc();
      #1 chk("t2_we2", MDU_WE_o, 0);
      chk("t3_stall2", Stall_o, 1);
      cyc();
      #1 chk("t2_we3", MDU_WE_o, 1);
      chk("t2_sel3", WBSel_o, 1);
      chk("t2_rd3", MDU_RD_o, 5);
      chk("t3_stall3", Stall_o, 1);
      cyc();
      #1 chk("t2_busy4", MDU_Busy_o, 0);
      chk("t2_we4", MDU_WE_o, 0);
      chk("t2_rd4", MDU_RD_o, 0);
      chk("t3_stall4", Stall_o, 0);
`ifdef MDU_STATS_EN
      chk("t3_cnt", Stall_Cnt_o, 4);
`else
      chk("t3_cnt", Stall_Cnt_o, 0);
`endif
      clr();
      cyc();

      // 4: divide blocked from the write port for two cycles
      IDEX_MDUValid_i = 1; IDEX_MDUOp_i = 1; IDEX_RD_i = 9;
      cyc();
      clr();
      for (int i = 1; i < 32; i++) begin
         #1 chk("t4_we", MDU_WE_o, 0);
         cyc();
      end
      MEMWB_RegWrite_i = 1;
      #1 chk("t4_we32", MDU_WE_o, 0);
      chk("t4_sel32", WBSel_o, 0);
      cyc();
      #1 chk("t4_we33", MDU_WE_o, 0);
      chk("t4_busy33", MDU_Busy_o, 1);
      cyc();
      MEMWB_RegWrite_i = 0;
      #1 chk("t4_we34", MDU_WE_o, 1);
      chk("t4_sel34", WBSel_o, 1);
      chk("t4_rd34", MDU_RD_o, 9);
      cyc();
      #1 chk("t4_we35", MDU_WE_o, 0);
      chk("t4_busy35", MDU_Busy_o, 0);
      cyc();

      // 5: back-to-back MDU ops (structural), then WAW on pending rd
      IDEX_MDUValid_i = 1; IDEX_RD_i = 3;
      IFID_MDUValid_i = 1; IFID_RD_i = 4; IFID_RegWrite_i = 1;
      #1 chk("t5_stall0", Stall_o, 1);
      cyc();
      IDEX_MDUValid_i = 0; IDEX_RD_i = 0;
      #1 chk("t5_stall1", Stall_o, 1);
      cyc();
      #1 chk("t5_stall2", Stall_o, 1);
      cyc();
      #1 chk("t5_stall3", Stall_o, 1);
      chk("t5_we3", MDU_WE_o, 1);
      chk("t5_rd3", MDU_RD_o, 3);
      cyc();
      #1 chk("t5_stall4", Stall_o, 0);
      cyc();
      clr();
      IDEX_MDUValid_i = 1; IDEX_RD_i = 4;
      #1 chk("t5_start2", MDU_Start_o, 1);
      cyc();
      clr();
      IFID_RD_i = 4; IFID_RegWrite_i = 1;
      #1 chk("t5_waw", Stall_o, 1);
      IFID_RegWrite_i = 0;
      #1 chk("t5_nowaw", Stall_o, 0);
      IFID_RT_i = 4;
      #1 chk("t5_rawrt", Stall_o, 1);
      clr();
      cyc();
      cyc();
      #1 chk("t5_we2", MDU_WE_o, 1);
      chk("t5_rd2", MDU_RD_o, 4);
      cyc();

      // 6: rd=0 runs full latency without stalls or writes
      IDEX_MDUValid_i = 1; IDEX_RD_i = 0;
      #1 chk("t6_stall0", Stall_o, 0);
      cyc();
      IDEX_MDUValid_i = 0;
      for (int i = 1; i < 4; i++) begin
         #1 chk("t6_stall", Stall_o, 0);
         chk("t6_we", MDU_WE_o, 0);
         chk("t6_sel", WBSel_o, 0);
         chk("t6_busy", MDU_Busy_o, 1);
         cyc();
      end
      #1 chk("t6_idle", MDU_Busy_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mdu_hazard_ctrl.md
Name: mdu_hazard_ctrl

Overview:
Controller for a multi-cycle multiply/divide unit (MDU) hanging off the EX stage of the 5-stage pipeline.
- Issues MDU operations from ID/EX and counts their latency.
- Keeps a one-entry scoreboard of the pending destination register and stalls decode on RAW, WAW and structural hazards.
- Arbitrates the single register-file write port between the normal MEM/WB writeback and MDU completion.

Parameters:
MUL_LAT, 3, cycles from issue to multiply result (>=1)
DIV_LAT, 32, cycles from issue to divide result (>=1)
CNT_W, 6, latency counter width (must hold max(MUL_LAT,DIV_LAT)-1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
IDEX_MDUValid_i  in  1  ID/EX holds an MDU op this cycle
IDEX_MDUOp_i  in  1  0=multiply, 1=divide
IDEX_RD_i  in  5  destination of the ID/EX MDU op
IFID_MDUValid_i  in  1  decode holds an MDU op
IFID_RS_i  in  5  decode source 1
IFID_RT_i  in  5  decode source 2
IFID_RD_i  in  5  decode destination
IFID_RegWrite_i  in  1  decode instruction writes a register
MEMWB_RegWrite_i  in  1  pipeline claims the write port this cycle
MDU_Start_o  out  1  one-cycle start pulse to the MDU
MDU_Op_o  out  1  latched op, valid while busy
Stall_o  out  1  hold PC and IF/ID, bubble into ID/EX
MDU_WE_o  out  1  MDU result written this cycle
MDU_RD_o  out  5  register written by the MDU
WBSel_o  out  1  write-port mux: 0=MEM/WB, 1=MDU
MDU_Busy_o  out  1  state != IDLE
Stall_Cnt_o  out  32  stall-cycle count (optional feature)

Behaviour:
Reset:
- state=IDLE; count, pend_rd, MDU_Op_o and Stall_Cnt_o cleared to 0.
- All outputs 0.
- Reset asserted mid-operation abandons the in-flight op; no write occurs.

States and transitions:
- IDLE
  - When IDEX_MDUValid_i=1: MDU_Start_o=1 (combinational, same cycle).
  - At the clock edge: latch pend_rd=IDEX_RD_i and op; count=(op? DIV_LAT:MUL_LAT)-1; go to BUSY.
- BUSY
  - count>0: decrement by 1 per cycle.
  - count==0 and MEMWB_RegWrite_i=0: MDU_WE_o=1, WBSel_o=1, then go to IDLE.
  - count==0 and MEMWB_RegWrite_i=1: go to WAIT_WB. The pipeline always wins the port.
- WAIT_WB
  - Hold until MEMWB_RegWrite_i=0.
  - In that cycle: MDU_WE_o=1, WBSel_o=1, then go to IDLE.

Write timing and target:
- The write occurs at issue+L cycles when the port is free; each cycle of port conflict adds exactly 1 cycle.
- pend_rd==0: the full latency sequence runs but MDU_WE_o stays 0. WBSel_o follows the same rule.
- MDU_RD_o = pend_rd whenever state != IDLE, otherwise 0.

Scoreboard register (combinational):
- P = pend_rd when state != IDLE.
- P = IDEX_RD_i when state==IDLE and IDEX_MDUValid_i=1.
- Otherwise no pending register.

Stall_o is combinational and asserts when any of the following hold:
- Structural: IFID_MDUValid_i and (state != IDLE or IDEX_MDUValid_i).
- RAW: P != 0 and (IFID_RS_i==P or IFID_RT_i==P).
- WAW: P != 0 and IFID_RegWrite_i and IFID_RD_i==P.

Stall release:
- Stall_o deasserts in the cycle after the MDU write.
- The register file handles the same-edge write-before-read.
- No stall is raised for P==0.

Optional Feature:
Macro MDU_STATS_EN.
- Defined: Stall_Cnt_o increments by 1 on every clock edge where Stall_o=1. It saturates at 32'hFFFFFFFF and clears on reset.
- Undefined: Stall_Cnt_o is tied to 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
1. Reset during BUSY.
   - Stimulus: issue DIV rd=8, assert rst_i at cycle 10.
   - Required: state IDLE immediately, MDU_WE_o never 1, Stall_o=0.
2. MUL timing.
   - Stimulus: MUL rd=5 issued at cycle 0 (MUL_LAT=3), MEMWB_RegWrite_i=0.
   - Required: MDU_Start_o=1 at cycle 0; MDU_WE_o=1 with MDU_RD_o=5 at cycle 3; MDU_Busy_o=0 at cycle 4.
3. RAW stall.
   - Stimulus: MUL rd=5 issued, next decode has IFID_RS_i=5.
   - Required: Stall_o=1 in cycles 0–3, 0 at cycle 4. With MDU_STATS_EN defined, Stall_Cnt_o=4.
4. Write-port conflict.
   - Stimulus: DIV rd=9, MEMWB_RegWrite_i=1 in cycles 32–33.
   - Required: WAIT_WB entered; MDU_WE_o=1, WBSel_o=1 at cycle 34 only.
5. Back-to-back MDU ops and WAW.
   - Stimulus: IDEX MUL rd=3 with IFID MUL rd=4 in the same cycle.
   - Required: Stall_o=1 until the rd=3 write, then the second op issues.
   - Also: decode ADD rd=3 while pending rd=3 gives Stall_o=1.
6. rd=0.
   - Stimulus: MUL rd=0, decode rs=0.
   - Required: Stall_o=0, MDU_WE_o=0 throughout, IDLE after 3 cycles.
